// File: rtl/ftm_pkg.sv
// Shared definitions for the fault-tolerance checkpoint memory and its restore reader.
// Also used by the checkpoint memory, so keep the word layout constants in sync with it.
package ftm_pkg;

  localparam int PC_WORD_IDX = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int IDX_W       = 6;
  localparam int WORD_SHIFT  = 2;

  typedef enum logic [2:0] {
    FTM_IDLE,
    FTM_REQ,
    FTM_WAIT,
    FTM_WRITE,
    FTM_DONE,
    FTM_ERROR
  } ftm_rst_state_e;

endpackage

// File: rtl/ft_restore_reader.sv
// Reads the checkpointed register file and PC from checkpoint memory, one word at a time,
// and replays each word into the recovering core as a register write or a PC load.
module ft_restore_reader
  import ftm_pkg::*;
#(
  parameter int          NUM_REGS  = 32,
  parameter int          PC_WORD   = PC_WORD_IDX,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic                 req_o,
  input  logic                 gnt_i,
  input  logic                 rvalid_i,
  output logic [31:0]          addr_o,
  input  logic [31:0]          rdata_i,
  input  logic                 err_i,
  output logic                 we_rf_o,
  output logic [RF_ADDR_W-1:0] addr_rf_o,
  output logic [31:0]          data_rf_o,
  output logic                 load_pc_o,
  output logic [31:0]          pc_o
);

  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_REG  = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] PC_IDX    = IDX_W'(PC_WORD);

  ftm_rst_state_e   state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      word_q;
  logic             error_q;
  logic             is_pc;

  assign is_pc = (idx_q == PC_IDX);

  // NOTE: every register here is a plain flop reset to a known value; non-blocking
  // assignments keep all of them updating from the same pre-edge snapshot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FTM_IDLE;
      idx_q   <= FIRST_IDX;
      word_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        FTM_IDLE: begin
          if (start_i) begin
            idx_q   <= FIRST_IDX;
            error_q <= 1'b0;
          end
        end
        FTM_WAIT: begin
          if (rvalid_i && !err_i) word_q <= rdata_i;
        end
        FTM_WRITE: begin
          // After the last register the index skips straight to the PC word.
          if (!is_pc) idx_q <= (idx_q == LAST_REG) ? PC_IDX : idx_q + 1'b1;
        end
        FTM_ERROR: error_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: a default assignment ahead of the case keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FTM_IDLE:  if (start_i) state_d = FTM_REQ;
      FTM_REQ:   if (gnt_i) state_d = FTM_WAIT;
      FTM_WAIT:  if (rvalid_i) state_d = err_i ? FTM_ERROR : FTM_WRITE;
      FTM_WRITE: state_d = is_pc ? FTM_DONE : FTM_REQ;
      FTM_DONE:  state_d = FTM_IDLE;
      FTM_ERROR: state_d = FTM_IDLE;
      default:   state_d = FTM_IDLE;
    endcase
  end

  always_comb begin
    req_o     = (state_q == FTM_REQ);
    busy_o    = (state_q == FTM_REQ) || (state_q == FTM_WAIT) || (state_q == FTM_WRITE);
    done_o    = (state_q == FTM_DONE);
    error_o   = error_q;
    we_rf_o   = (state_q == FTM_WRITE) && !is_pc;
    load_pc_o = (state_q == FTM_WRITE) && is_pc;
    addr_o    = '0;
    addr_rf_o = '0;
    if (req_o) addr_o = BASE_ADDR + (32'(idx_q) << WORD_SHIFT);
    if (we_rf_o) addr_rf_o = idx_q[RF_ADDR_W-1:0];
    data_rf_o = word_q;
    pc_o      = word_q;
  end

endmodule

// File: tb/tb_ft_restore_reader.sv
// Randomised bench for ft_restore_reader: a checkpoint-memory responder plus a
// transaction-level model of the restore sequence, checked every cycle on two base addresses.
module tb_ft_restore_reader;

  localparam int NUM_REGS = 32;
  localparam int PC_WORD  = 32;
  localparam logic [31:0] BASE1 = 32'h100;

  logic        clk_i, rst_i, start_i, gnt_i, rvalid_i, err_i;
  logic [31:0] rdata_i;
  logic        busy0, done0, error0, req0, we0, load0;
  logic        busy1, done1, error1, req1, we1, load1;
  logic [31:0] addr0, addr1, data_rf0, data_rf1, pc0, pc1;
  logic [4:0]  addr_rf0, addr_rf1;

  ft_restore_reader #(.NUM_REGS(NUM_REGS), .PC_WORD(PC_WORD), .BASE_ADDR(32'h0)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .busy_o(busy0), .done_o(done0),
    .error_o(error0), .req_o(req0), .gnt_i(gnt_i), .rvalid_i(rvalid_i), .addr_o(addr0),
    .rdata_i(rdata_i), .err_i(err_i), .we_rf_o(we0), .addr_rf_o(addr_rf0),
    .data_rf_o(data_rf0), .load_pc_o(load0), .pc_o(pc0));

  ft_restore_reader #(.NUM_REGS(NUM_REGS), .PC_WORD(PC_WORD), .BASE_ADDR(BASE1)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .busy_o(busy1), .done_o(done1),
    .error_o(error1), .req_o(req1), .gnt_i(gnt_i), .rvalid_i(rvalid_i), .addr_o(addr1),
    .rdata_i(rdata_i), .err_i(err_i), .we_rf_o(we1), .addr_rf_o(addr_rf1),
    .data_rf_o(data_rf1), .load_pc_o(load1), .pc_o(pc1));

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Checkpoint memory contents, shared by responder and model.
  logic [31:0] mem [0:PC_WORD];

  function automatic logic [31:0] mem_rd(input int w);
    return (w >= 0 && w <= PC_WORD) ? mem[w] : 32'hDEAD_BEEF;
  endfunction

  // Restore order: registers 1..NUM_REGS-1, then the PC word.
  function automatic int word_of(input int pos);
    return (pos < NUM_REGS - 1) ? pos + 1 : PC_WORD;
  endfunction

  // Responder configuration and state.
  int cfg_gnt_fixed = 0;
  bit cfg_rv_rand   = 0;
  bit cfg_spur      = 0;
  int cfg_err_word  = -1;
  int cfg_rst_word  = -1;
  bit drv_start_req = 0;
  bit drv_pending   = 0;
  int drv_rv_cnt    = 0;
  int drv_gnt_cnt   = 0;
  int drv_word      = 0;
  int drv_rst_cnt   = 3;

  function automatic int gnt_delay();
    return (cfg_gnt_fixed >= 0) ? cfg_gnt_fixed : int'($urandom_range(0, 3));
  endfunction

  // Model state.
  bit m_zero_next = 1;
  bit m_run = 0, m_req_due = 0, m_outstanding = 0, m_strobe_due = 0, m_done_due = 0;
  bit m_err_exp = 0, m_first_req = 0;
  int m_err_phase = 0, m_rd_pos = 0, m_wr_pos = 0;

  // Observed statistics per restore.
  int cyc = 0, n_we = 0, n_pc = 0, n_done = 0, first_req_cyc = 0, pc_cyc = 0;
  logic [31:0] first_we_addr, first_we_data, last_pc, first_addr1, last_addr1;

  // Memory responder and stimulus driver: all inputs change 1 time unit after posedge.
  initial begin
    start_i = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; err_i = 1'b0; rst_i = 1'b1;
    forever begin
      @(posedge clk_i); #1;
      rst_i = (drv_rst_cnt > 0);
      if (drv_rst_cnt > 0) drv_rst_cnt--;
      start_i = 1'b0;
      if (drv_start_req) begin
        start_i = 1'b1;
        drv_start_req = 0;
      end else if (cfg_spur && m_run && $urandom_range(0, 7) == 0) begin
        start_i = 1'b1;
      end
      rvalid_i = 1'b0; err_i = 1'b0; rdata_i = $urandom;
      if (drv_pending) begin
        if (drv_rv_cnt == 0) begin
          rvalid_i = 1'b1;
          rdata_i  = mem_rd(drv_word);
          err_i    = (drv_word == cfg_err_word);
          drv_pending = 0;
        end else drv_rv_cnt--;
      end else if (cfg_spur && req0 && $urandom_range(0, 2) == 0) begin
        rvalid_i = 1'b1;
        err_i    = 1'($urandom);
      end
      gnt_i = 1'b0;
      if (req0 && !drv_pending) begin
        if (drv_gnt_cnt == 0) begin
          gnt_i       = 1'b1;
          drv_pending = 1;
          drv_word    = int'(addr0 >> 2);
          drv_rv_cnt  = cfg_rv_rand ? int'($urandom_range(0, 2)) : 0;
          if (drv_word == cfg_rst_word) begin
            drv_rst_cnt = 1;
            drv_rv_cnt  = 2;
          end
          drv_gnt_cnt = gnt_delay();
        end else drv_gnt_cnt--;
      end
    end
  end

  // Compare process: outputs sampled on the falling edge against the model.
  bit exp_busy, exp_we, exp_load, accept, pc_now;
  int w;
  always @(negedge clk_i) begin
    cyc++;
    exp_busy = m_run && !m_done_due && (m_err_phase == 0);
    exp_we   = m_strobe_due && (m_wr_pos < NUM_REGS - 1);
    exp_load = m_strobe_due && (m_wr_pos == NUM_REGS - 1);
    accept   = start_i && !rst_i && !m_run;
    pc_now   = 0;
    if (m_zero_next) begin
      check("reset_ctl0", {busy0, done0, error0, req0, we0, load0}, 0);
      check("reset_ctl1", {busy1, done1, error1, req1, we1, load1}, 0);
      check("reset_data0", {addr0, addr_rf0, data_rf0, pc0}, 0);
      check("reset_data1", {addr1, addr_rf1, data_rf1, pc1}, 0);
      m_zero_next = 0;
    end else begin
      check("ctl0", {busy0, done0, error0, req0, we0, load0},
            {exp_busy, m_done_due, m_err_exp, m_req_due, exp_we, exp_load});
      check("ctl1", {busy1, done1, error1, req1, we1, load1},
            {exp_busy, m_done_due, m_err_exp, m_req_due, exp_we, exp_load});
      if (m_req_due) begin
        check("addr0", addr0, 32'(4 * word_of(m_rd_pos)));
        check("addr1", addr1, BASE1 + 32'(4 * word_of(m_rd_pos)));
        if (m_first_req) begin
          first_req_cyc = cyc;
          first_addr1   = addr1;
          m_first_req   = 0;
        end
        last_addr1 = addr1;
      end
      if (m_strobe_due) begin
        w = word_of(m_wr_pos);
        if (exp_load) begin
          check("pc0", pc0, mem_rd(PC_WORD));
          check("pc1", pc1, mem_rd(PC_WORD));
          n_pc++; pc_cyc = cyc; last_pc = pc0; pc_now = 1;
        end else begin
          check("addr_rf", {addr_rf0, addr_rf1}, {5'(w), 5'(w)});
          check("data_rf", {data_rf0, data_rf1}, {mem_rd(w), mem_rd(w)});
          if (n_we == 0) begin
            first_we_addr = 32'(addr_rf0);
            first_we_data = data_rf0;
          end
          n_we++;
        end
        m_wr_pos++;
      end
    end
    if (done0) n_done++;
    // Advance the model to the next cycle.
    if (m_done_due) begin m_done_due = 0; m_run = 0; end
    if (m_err_phase == 1) begin m_err_phase = 0; m_err_exp = 1; m_run = 0; end
    if (m_strobe_due) begin
      m_strobe_due = 0;
      if (pc_now) m_done_due = 1;
      else m_req_due = 1;
    end
    if (m_req_due && gnt_i) begin m_req_due = 0; m_outstanding = 1; m_rd_pos++; end
    else if (rvalid_i && m_outstanding) begin
      m_outstanding = 0;
      if (err_i) m_err_phase = 1;
      else m_strobe_due = 1;
    end
    if (accept) begin
      m_run = 1; m_err_exp = 0; m_req_due = 1; m_rd_pos = 0; m_wr_pos = 0; m_first_req = 1;
    end
    if (rst_i) begin
      m_run = 0; m_req_due = 0; m_outstanding = 0; m_strobe_due = 0; m_done_due = 0;
      m_err_phase = 0; m_err_exp = 0; m_zero_next = 1;
    end
  end

  task automatic load_mem(input bit rand_data);
    for (int i = 0; i < PC_WORD; i++) mem[i] = rand_data ? $urandom : 32'hA000_0000 + 32'(i);
    mem[PC_WORD] = rand_data ? $urandom : 32'h0000_0180;
  endtask

  task automatic run_restore(input int budget);
    bit started, finished;
    started = 0; finished = 0;
    for (int i = 0; i < 20 && drv_pending; i++) @(posedge clk_i);
    @(posedge clk_i); #2;
    n_we = 0; n_pc = 0; n_done = 0; first_req_cyc = 0; pc_cyc = 0;
    drv_gnt_cnt = gnt_delay();
    drv_start_req = 1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_i); #2;
      if (m_run) started = 1;
      else if (started) begin finished = 1; break; end
    end
    check("restore_completes", finished, 1);
    repeat (2) @(posedge clk_i);
    #2;
  endtask

  initial begin
    load_mem(0);
    repeat (6) @(posedge clk_i);

    // Zero-wait memory, full restore.
    run_restore(300);
    check("t1_we_count", n_we, 31);
    check("t1_pc_count", n_pc, 1);
    check("t1_done_count", n_done, 1);
    check("t1_latency", pc_cyc - first_req_cyc + 1, 96);
    check("t1_first_we", {first_we_addr, first_we_data}, {32'd1, 32'hA000_0001});
    check("t1_pc_value", last_pc, 32'h0000_0180);
    check("t1_first_addr_base100", first_addr1, 32'h104);
    check("t1_pc_addr_base100", last_addr1, 32'h180);

    // Grant delayed by three cycles on every request.
    cfg_gnt_fixed = 3;
    run_restore(600);
    check("t2_latency", pc_cyc - first_req_cyc + 1, 96 + 31 * 3 + 3);
    check("t2_we_count", n_we, 31);

    // Error response on index 5.
    cfg_gnt_fixed = 0; cfg_err_word = 5;
    run_restore(300);
    check("t3_we_count", n_we, 4);
    check("t3_no_pc_no_done", n_pc + n_done, 0);
    check("t3_error_sticky", error0, 1);
    cfg_err_word = -1;
    run_restore(300);
    check("t3_error_cleared", error0, 0);
    check("t3_recovery_we", n_we, 31);

    // Reset while waiting on index 10; late rvalid must be ignored.
    cfg_rst_word = 10;
    run_restore(300);
    check("t4_we_before_reset", n_we, 9);
    check("t4_no_pc", n_pc, 0);
    cfg_rst_word = -1;
    repeat (4) @(posedge clk_i);
    run_restore(300);
    check("t4_restart_first", first_we_addr, 32'd1);
    check("t4_restart_pc", n_pc, 1);

    // Random data, random delays, spurious rvalid and start pulses.
    cfg_gnt_fixed = -1; cfg_rv_rand = 1; cfg_spur = 1;
    for (int r = 0; r < 6; r++) begin
      load_mem(1);
      run_restore(800);
      check("t5_we_count", n_we, 31);
      check("t5_pc_value", last_pc, mem[PC_WORD]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
